// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types and constants for the DES job scheduler
package des_pkg;

    localparam int DES_BLOCK_W = 64;

    // Requester tags double as the grant-vector bit index
    localparam logic TAG_ENC = 1'b0;
    localparam logic TAG_DEC = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CORE,
        HOLD,
        ERROR
    } sched_state_t;

endpackage

// File: rtl/des_rr_arbiter.sv
// rtl/des_rr_arbiter.sv - two-way round-robin arbiter owning the last-grant history
module des_rr_arbiter
    import des_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant;

    // A lone requester always wins; on a tie the side not served last wins
    always_comb begin
        gnt = 2'b00;
        if (req[TAG_ENC] && (!req[TAG_DEC] || last_grant == TAG_DEC)) begin
            gnt[TAG_ENC] = 1'b1;
        end else if (req[TAG_DEC]) begin
            gnt[TAG_DEC] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_grant <= TAG_DEC;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[TAG_DEC];
        end
    end

endmodule

// File: rtl/des_job_scheduler.sv
// rtl/des_job_scheduler.sv - shares one DES engine between the ENC and DEC requesters
module des_job_scheduler
    import des_pkg::*;
#(
    parameter int DATA_W  = DES_BLOCK_W,
    parameter int TIMEOUT = 96
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enc_valid,
    input  logic [DATA_W-1:0] enc_data,
    output logic              enc_ready,
    input  logic              dec_valid,
    input  logic [DATA_W-1:0] dec_data,
    output logic              dec_ready,
    output logic              core_start,
    output logic              core_encrypt,
    output logic [DATA_W-1:0] core_data_in,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_data_out,
    output logic              res_valid,
    output logic              res_tag,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    output logic              err_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] WDOG_MAX  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] WDOG_LAST = TMO_W'(TIMEOUT - 1);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             grant;
    logic [TMO_W-1:0] wdog;

    assign req   = {dec_valid, enc_valid};
    assign grant = enc_ready | dec_ready;

    des_rr_arbiter u_arb (
        .clk     (clk),
        .n_rst   (n_rst),
        .req     (req),
        .advance (grant),
        .gnt     (gnt)
    );

    // Readies are gated by n_rst so nothing is accepted while reset is asserted
    always_comb begin
        state_nxt  = state;
        enc_ready  = 1'b0;
        dec_ready  = 1'b0;
        core_start = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (n_rst && (req != 2'b00)) begin
                    enc_ready = gnt[TAG_ENC];
                    dec_ready = gnt[TAG_DEC];
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                state_nxt  = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (core_done) begin
                    state_nxt = HOLD;
                end else if (wdog == WDOG_LAST) begin
                    state_nxt = ERROR;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            core_encrypt <= 1'b0;
            core_data_in <= '0;
            res_tag      <= 1'b0;
            res_data     <= '0;
            err_timeout  <= 1'b0;
            wdog         <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                core_data_in <= dec_ready ? dec_data : enc_data;
                core_encrypt <= enc_ready;
                res_tag      <= dec_ready ? TAG_DEC : TAG_ENC;
            end
            // Watchdog counts WAIT_CORE cycles; the last one still honours core_done
            if (state == ISSUE) begin
                wdog <= '0;
            end else if (state == WAIT_CORE && wdog != WDOG_MAX) begin
                wdog <= wdog + 1'b1;
            end
            if (state == WAIT_CORE && core_done) begin
                res_data <= core_data_out;
            end
            if (state == WAIT_CORE && !core_done && wdog == WDOG_LAST) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_des_job_scheduler.sv
// tb/tb_des_job_scheduler.sv - self-checking bench for des_job_scheduler
module tb_des_job_scheduler;

    localparam int TIMEOUT = 96;

    logic        clk;
    logic        n_rst;
    logic        enc_valid;
    logic [63:0] enc_data;
    logic        enc_ready;
    logic        dec_valid;
    logic [63:0] dec_data;
    logic        dec_ready;
    logic        core_start;
    logic        core_encrypt;
    logic [63:0] core_data_in;
    logic        core_done;
    logic [63:0] core_data_out;
    logic        res_valid;
    logic        res_tag;
    logic [63:0] res_data;
    logic        res_ready;
    logic        err_timeout;

    des_job_scheduler #(.DATA_W(64), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .enc_valid     (enc_valid),
        .enc_data      (enc_data),
        .enc_ready     (enc_ready),
        .dec_valid     (dec_valid),
        .dec_data      (dec_data),
        .dec_ready     (dec_ready),
        .core_start    (core_start),
        .core_encrypt  (core_encrypt),
        .core_data_in  (core_data_in),
        .core_done     (core_done),
        .core_data_out (core_data_out),
        .res_valid     (res_valid),
        .res_tag       (res_tag),
        .res_data      (res_data),
        .res_ready     (res_ready),
        .err_timeout   (err_timeout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] eng_fn(input logic [63:0] d);
        return {d[31:0], d[63:32]} ^ 64'h5A5A_0F0F_C3C3_9696;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural DES engine: answers done_delay cycles after the start pulse (0 = never)
    int          done_delay = 0;
    logic        eng_ovr_en = 1'b0;
    logic [63:0] eng_ovr_val = '0;
    logic        eng_armed = 1'b0;
    int          eng_cnt = 0;
    logic [63:0] eng_res = '0;

    initial begin
        core_done     = 1'b0;
        core_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (!n_rst) begin
                eng_armed = 1'b0;
            end else if (eng_armed) begin
                eng_cnt++;
                if (done_delay != 0 && eng_cnt == done_delay) begin
                    core_done     = 1'b1;
                    core_data_out = eng_res;
                    eng_armed     = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (n_rst && core_start) begin
            eng_armed = 1'b1;
            eng_cnt   = 0;
            eng_res   = eng_ovr_en ? eng_ovr_val : eng_fn(core_data_in);
        end
    end

    // Transaction-level model: one job open at a time, round-robin on ties, watchdog in wait cycles
    logic        m_open = 1'b0;
    logic        m_tag = 1'b0;
    logic [63:0] m_data = '0;
    logic        m_start_due = 1'b0;
    int          m_wait = 0;
    logic        m_have_res = 1'b0;
    logic [63:0] m_res = '0;
    logic        m_err = 1'b0;
    logic        m_last = 1'b1;

    always @(negedge clk) begin
        logic can, e_enc, e_dec, e_rv;
        if (!n_rst) begin
            m_open = 1'b0; m_start_due = 1'b0; m_have_res = 1'b0;
            m_err = 1'b0; m_last = 1'b1; m_wait = 0;
            chk("m_rst_ctl", 64'({enc_ready, dec_ready, core_start, core_encrypt,
                                  res_valid, res_tag, err_timeout}), 64'd0);
            chk("m_rst_data", core_data_in | res_data, 64'd0);
        end else begin
            can   = !m_open && !m_err;
            e_enc = can && enc_valid && (!dec_valid || m_last);
            e_dec = can && dec_valid && (!enc_valid || !m_last);
            e_rv  = m_have_res;
            chk("m_enc_ready", 64'(enc_ready), 64'(e_enc));
            chk("m_dec_ready", 64'(dec_ready), 64'(e_dec));
            chk("m_core_start", 64'(core_start), 64'(m_start_due));
            chk("m_res_valid", 64'(res_valid), 64'(e_rv));
            chk("m_err_timeout", 64'(err_timeout), 64'(m_err));
            if (e_rv) begin
                chk("m_res_tag", 64'(res_tag), 64'(m_tag));
                chk("m_res_data", res_data, m_res);
            end
            if (m_open) begin
                chk("m_core_encrypt", 64'(core_encrypt), 64'(!m_tag));
                chk("m_core_data_in", core_data_in, m_data);
            end
            if (m_open && !m_start_due && !m_have_res) begin
                m_wait++;
                if (core_done) begin
                    m_have_res = 1'b1;
                    m_res      = core_data_out;
                end else if (m_wait == TIMEOUT) begin
                    m_err  = 1'b1;
                    m_open = 1'b0;
                end
            end
            if (e_rv && res_ready) begin
                m_open     = 1'b0;
                m_have_res = 1'b0;
            end
            m_start_due = 1'b0;
            if (e_enc || e_dec) begin
                m_open      = 1'b1;
                m_tag       = e_dec;
                m_data      = e_dec ? dec_data : enc_data;
                m_last      = e_dec;
                m_start_due = 1'b1;
                m_wait      = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        n_rst = 1'b0; enc_valid = 1'b0; dec_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        chk("reset_ctl", 64'({enc_ready, dec_ready, core_start, core_encrypt,
                              res_valid, res_tag, err_timeout}), 64'd0);
        chk("reset_data", core_data_in | res_data, 64'd0);
        step();
        n_rst = 1'b1;
    endtask

    task automatic wait_res(input int max, output int n);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) chk("res_wait_bound", 64'd0, 64'd1);
    endtask

    task automatic handoff();
        step(); res_ready = 1'b1;
        step(); res_ready = 1'b0;
    endtask

    initial begin
        int n;
        int gs[$];
        int ms[$];
        int ts[$];
        int exp_g[4];
        int exp_m[4];
        int cyc;
        n_rst = 1'b0; enc_valid = 1'b0; dec_valid = 1'b0; res_ready = 1'b0;
        enc_data = '0; dec_data = '0;

        // 1: single ENC job, known result after 70 wait cycles
        do_reset();
        eng_ovr_en = 1'b1; eng_ovr_val = 64'h85E8_1354_0F0A_B405; done_delay = 70;
        step(); enc_valid = 1'b1; enc_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        chk("t1_enc_ready", 64'(enc_ready), 64'd1);
        chk("t1_no_start_yet", 64'(core_start), 64'd0);
        step(); enc_valid = 1'b0;
        @(negedge clk);
        chk("t1_core_start", 64'(core_start), 64'd1);
        chk("t1_core_encrypt", 64'(core_encrypt), 64'd1);
        chk("t1_core_data_in", core_data_in, 64'h0123_4567_89AB_CDEF);
        wait_res(200, n);
        chk("t1_res_cycles", 64'(n), 64'd70);
        chk("t1_res_tag", 64'(res_tag), 64'd0);
        chk("t1_res_data", res_data, 64'h85E8_1354_0F0A_B405);
        handoff();
        eng_ovr_en = 1'b0;

        // 2: both requesters saturated -> strict alternation starting with ENC
        do_reset();
        done_delay = 5; res_ready = 1'b1;
        enc_data = 64'hE1E1_0000_1111_2222; dec_data = 64'hD1D1_3333_4444_5555;
        step(); enc_valid = 1'b1; dec_valid = 1'b1;
        cyc = 0;
        while (ts.size() < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (enc_ready) gs.push_back(0);
            if (dec_ready) gs.push_back(1);
            if (core_start) ms.push_back(int'(core_encrypt));
            if (res_valid) ts.push_back(int'(res_tag));
        end
        step(); enc_valid = 1'b0; dec_valid = 1'b0; res_ready = 1'b0;
        exp_g = '{0, 1, 0, 1};
        exp_m = '{1, 0, 1, 0};
        chk("t2_grant_count", 64'(gs.size()), 64'd4);
        chk("t2_result_count", 64'(ts.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gs.size()) chk($sformatf("t2_grant%0d", i), 64'(gs[i]), 64'(exp_g[i]));
            if (i < ms.size()) chk($sformatf("t2_mode%0d", i), 64'(ms[i]), 64'(exp_m[i]));
            if (i < ts.size()) chk($sformatf("t2_tag%0d", i), 64'(ts[i]), 64'(exp_g[i]));
        end

        // 3: 20 cycles of result backpressure with ENC still requesting
        do_reset();
        done_delay = 4;
        step(); enc_valid = 1'b1; enc_data = 64'hC3C3_A5A5_0102_0304;
        wait_res(50, n);
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            chk("t3_hold_valid", 64'(res_valid), 64'd1);
            chk("t3_hold_data", res_data, eng_fn(64'hC3C3_A5A5_0102_0304));
            chk("t3_hold_quiet", 64'({enc_ready, dec_ready, core_start}), 64'd0);
        end
        step(); res_ready = 1'b1;
        @(negedge clk);
        chk("t3_bubble", 64'(enc_ready), 64'd0);
        step(); res_ready = 1'b0;
        @(negedge clk);
        chk("t3_regrant", 64'(enc_ready), 64'd1);
        step(); enc_valid = 1'b0;
        @(negedge clk);
        chk("t3_restart", 64'(core_start), 64'd1);
        wait_res(50, n);
        handoff();

        // 4: engine never answers -> sticky timeout after 96 wait cycles, recovery via reset
        do_reset();
        done_delay = 0;
        step(); dec_valid = 1'b1; dec_data = 64'hDEAD_BEEF_0000_0001;
        step(); dec_valid = 1'b0;
        @(negedge clk);
        chk("t4_core_start", 64'(core_start), 64'd1);
        n = 0;
        do begin
            @(negedge clk);
            if (!err_timeout) n++;
        end while (!err_timeout && n < 300);
        chk("t4_wait_cycles", 64'(n), 64'd96);
        step(); enc_valid = 1'b1; dec_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_stalled", 64'({enc_ready, dec_ready, core_start, res_valid}), 64'd0);
            chk("t4_sticky", 64'(err_timeout), 64'd1);
            step();
        end
        do_reset();
        done_delay = 3;
        step(); enc_valid = 1'b1; enc_data = 64'h1122_3344_5566_7788;
        @(negedge clk);
        chk("t4_resume_grant", 64'(enc_ready), 64'd1);
        step(); enc_valid = 1'b0;
        wait_res(50, n);
        chk("t4_resume_tag", 64'(res_tag), 64'd0);
        chk("t4_resume_data", res_data, eng_fn(64'h1122_3344_5566_7788));
        handoff();

        // 5: done on the last permitted wait cycle beats the watchdog
        done_delay = 96;
        step(); dec_valid = 1'b1; dec_data = 64'hFEDC_BA98_7654_3210;
        step(); dec_valid = 1'b0;
        @(negedge clk);
        chk("t5_core_start", 64'(core_start), 64'd1);
        wait_res(300, n);
        chk("t5_res_cycles", 64'(n), 64'd96);
        chk("t5_no_error", 64'(err_timeout), 64'd0);
        chk("t5_res_tag", 64'(res_tag), 64'd1);
        chk("t5_res_data", res_data, eng_fn(64'hFEDC_BA98_7654_3210));
        handoff();

        // 6: asynchronous reset in the middle of an ENC job, then ENC wins the tie again
        done_delay = 0;
        step(); enc_valid = 1'b1; enc_data = 64'h0F0F_0F0F_F0F0_F0F0;
        step(); enc_valid = 1'b0;
        repeat (10) step();
        n_rst = 1'b0;
        #1;
        chk("t6_async_ctl", 64'({enc_ready, dec_ready, core_start, core_encrypt,
                                 res_valid, res_tag, err_timeout}), 64'd0);
        chk("t6_async_data", core_data_in | res_data, 64'd0);
        step();
        step();
        n_rst = 1'b1; done_delay = 3;
        enc_valid = 1'b1; dec_valid = 1'b1;
        enc_data = 64'hAAAA_5555_AAAA_5555; dec_data = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk);
        chk("t6_enc_first", 64'({enc_ready, dec_ready}), 64'b10);
        step(); enc_valid = 1'b0; dec_valid = 1'b0;
        wait_res(50, n);
        chk("t6_res_tag", 64'(res_tag), 64'd0);
        chk("t6_res_data", res_data, eng_fn(64'hAAAA_5555_AAAA_5555));
        handoff();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1);
    end

endmodule
